// File: rtl/core_bus_pkg.sv
// Shared types and constants for the core naive-bus arbiter.
package core_bus_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  // Master indices: the instruction port is m0, the data port is m1.
  localparam logic M_INSTR = 1'b0;
  localparam logic M_DATA  = 1'b1;

endpackage

// File: rtl/core_bus_wait_counter.sv
// Saturating up-counter measuring how long a master waited for the bus.
module core_bus_wait_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count stalled cycles; stick at all-ones so the value never wraps.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (rst)
      cnt <= '0;
    else if (inc && (cnt != {CNT_W{1'b1}}))
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/core_bus_arbiter.sv
// Two-master, one-slave arbiter: round-robin or m1-priority, ownership held
// until the slave accepts, read data steered back one cycle after its grant.
module core_bus_arbiter
  import core_bus_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int PRIO_M1 = 0,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  // master 0 (instruction)
  input  logic              m0_rd_req,
  input  logic [AW-1:0]     m0_rd_addr,
  output logic              m0_rd_gnt,
  output logic [DW-1:0]     m0_rd_data,
  input  logic              m0_wr_req,
  input  logic [AW-1:0]     m0_wr_addr,
  input  logic [DW-1:0]     m0_wr_data,
  input  logic [DW/8-1:0]   m0_wr_be,
  output logic              m0_wr_gnt,
  output logic [CNT_W-1:0]  m0_wait_cnt,
  // master 1 (data)
  input  logic              m1_rd_req,
  input  logic [AW-1:0]     m1_rd_addr,
  output logic              m1_rd_gnt,
  output logic [DW-1:0]     m1_rd_data,
  input  logic              m1_wr_req,
  input  logic [AW-1:0]     m1_wr_addr,
  input  logic [DW-1:0]     m1_wr_data,
  input  logic [DW/8-1:0]   m1_wr_be,
  output logic              m1_wr_gnt,
  output logic [CNT_W-1:0]  m1_wait_cnt,
  // slave
  output logic              s_rd_req,
  output logic [AW-1:0]     s_rd_addr,
  input  logic              s_rd_gnt,
  input  logic [DW-1:0]     s_rd_data,
  output logic              s_wr_req,
  output logic [AW-1:0]     s_wr_addr,
  output logic [DW-1:0]     s_wr_data,
  output logic [DW/8-1:0]   s_wr_be,
  input  logic              s_wr_gnt
);

  arb_state_e state_q, state_d;
  logic       hold_owner_q, last_served_q, rd_owner_q, rd_pend_q;
  logic       req0, req1, owner_vld, owner, owner_req;
  logic       rd_accept, accept;

  assign req0 = m0_rd_req | m0_wr_req;
  assign req1 = m1_rd_req | m1_wr_req;

  // Pick the owner: a held master keeps the bus, otherwise arbitrate.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    owner_vld = 1'b0;
    owner     = M_INSTR;
    if (state_q == ARB_HOLD) begin
      owner_vld = 1'b1;
      owner     = hold_owner_q;
    end else if (req0 && req1) begin
      owner_vld = 1'b1;
      owner     = (PRIO_M1 != 0) ? M_DATA : ~last_served_q;
    end else if (req0) begin
      owner_vld = 1'b1;
      owner     = M_INSTR;
    end else if (req1) begin
      owner_vld = 1'b1;
      owner     = M_DATA;
    end
  end

  // Mirror the owner's request and payload onto the slave; zeros when idle.
  always_comb begin
    s_rd_req  = 1'b0;
    s_rd_addr = '0;
    s_wr_req  = 1'b0;
    s_wr_addr = '0;
    s_wr_data = '0;
    s_wr_be   = '0;
    owner_req = 1'b0;
    if (owner_vld) begin
      if (owner == M_DATA) begin
        s_rd_req  = m1_rd_req;
        s_rd_addr = m1_rd_addr;
        s_wr_req  = m1_wr_req;
        s_wr_addr = m1_wr_addr;
        s_wr_data = m1_wr_data;
        s_wr_be   = m1_wr_be;
        owner_req = req1;
      end else begin
        s_rd_req  = m0_rd_req;
        s_rd_addr = m0_rd_addr;
        s_wr_req  = m0_wr_req;
        s_wr_addr = m0_wr_addr;
        s_wr_data = m0_wr_data;
        s_wr_be   = m0_wr_be;
        owner_req = req0;
      end
    end
  end

  // Slave grants pass straight through to the owner only.
  assign m0_rd_gnt = owner_vld && (owner == M_INSTR) && s_rd_gnt;
  assign m0_wr_gnt = owner_vld && (owner == M_INSTR) && s_wr_gnt;
  assign m1_rd_gnt = owner_vld && (owner == M_DATA)  && s_rd_gnt;
  assign m1_wr_gnt = owner_vld && (owner == M_DATA)  && s_wr_gnt;

  assign rd_accept = s_rd_req & s_rd_gnt;
  assign accept    = rd_accept | (s_wr_req & s_wr_gnt);

  // Next state: hold an unaccepted owner; release on accept or abandon.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (owner_vld && !accept) state_d = ARB_HOLD;
      ARB_HOLD: if (accept || !owner_req) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ARB_IDLE;
    else     state_q <= state_d;
  end

  // Arbitration history and read-return bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_owner_q  <= M_INSTR;
      last_served_q <= M_DATA;
      rd_owner_q    <= M_INSTR;
      rd_pend_q     <= 1'b0;
    end else begin
      if (state_q == ARB_IDLE && owner_vld && !accept) hold_owner_q <= owner;
      if (accept) last_served_q <= owner;
      if (rd_accept) rd_owner_q <= owner;
      rd_pend_q <= rd_accept;
    end
  end

  assign m0_rd_data = (rd_pend_q && rd_owner_q == M_INSTR) ? s_rd_data : '0;
  assign m1_rd_data = (rd_pend_q && rd_owner_q == M_DATA)  ? s_rd_data : '0;

  core_bus_wait_counter #(.CNT_W(CNT_W)) u_wait_m0 (
    .clk (clk),
    .rst (rst),
    .inc (req0 && !(m0_rd_gnt || m0_wr_gnt)),
    .cnt (m0_wait_cnt)
  );

  core_bus_wait_counter #(.CNT_W(CNT_W)) u_wait_m1 (
    .clk (clk),
    .rst (rst),
    .inc (req1 && !(m1_rd_gnt || m1_wr_gnt)),
    .cnt (m1_wait_cnt)
  );

endmodule
